vga_timing: RTL

VGA_TIMING -- requirements
Module: vga_timing

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vga_pix_div.sv | 29 ++
 rtl/vga_timing.sv | 115 +++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, colour type and helpers for the VGA timing block.
package vga_pkg;

    localparam int CNT_W   = 11;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [11:0]      rgb12_t;

    localparam int VGA_CLK_DIV = 2;
    localparam int VGA_H_VIS   = 640;
    localparam int VGA_H_FP    = 16;
    localparam int VGA_H_SY    = 96;
    localparam int VGA_H_BP    = 48;
    localparam int VGA_V_VIS   = 480;
    localparam int VGA_V_FP    = 10;
    localparam int VGA_V_SY    = 2;
    localparam int VGA_V_BP    = 33;

    localparam rgb12_t RGB_WHITE = 12'hFFF;
    localparam rgb12_t RGB_BLACK = 12'h000;
    localparam rgb12_t RGB_BLANK = 12'h000;

    typedef struct packed {
        rgb12_t rgb;
        logic   hsync;
        logic   vsync;
    } vid_out_t;

    localparam vid_out_t VID_RESET = '{rgb: RGB_BLANK, hsync: 1'b1, vsync: 1'b1};

    function automatic logic in_range(cnt_t val, cnt_t lo, cnt_t hi);
        return (val >= lo) && (val < hi);
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-enable divider: one-cycle strobe every CLK_DIV system clocks.
module vga_pix_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pix_en
);

    // A one-bit counter pinned at zero covers CLK_DIV=1 without a special case.
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) div_q <= '0;
        else        div_q <= div_d;
    end

    // Gating with rst_n holds the strobe low in reset even when CLK_DIV=1.
    assign pix_en = rst_n && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_timing.sv
// VGA raster timing: pixel/line counters, registered sync and colour, frame strobe.
// Optional frame counter enabled by defining VGA_TIMING_FRAME_CNT_EN.
module vga_timing
    import vga_pkg::*;
#(
    parameter int     CLK_DIV = VGA_CLK_DIV,
    parameter int     H_VIS   = VGA_H_VIS,
    parameter int     H_FP    = VGA_H_FP,
    parameter int     H_SY    = VGA_H_SY,
    parameter int     H_BP    = VGA_H_BP,
    parameter int     V_VIS   = VGA_V_VIS,
    parameter int     V_FP    = VGA_V_FP,
    parameter int     V_SY    = VGA_V_SY,
    parameter int     V_BP    = VGA_V_BP,
    parameter rgb12_t FG_RGB  = RGB_WHITE,
    parameter rgb12_t BG_RGB  = RGB_BLACK
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        PAINT,
    output logic [10:0] HCOUNT,
    output logic [10:0] VCOUNT,
    output logic        PIX_EN,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic [11:0] RGB,
    output logic        FRAME_START,
    output logic [7:0]  FRAME_CNT
);

    localparam int H_TOT = H_VIS + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SY + V_BP;

    generate
        if (H_TOT > CNT_MAX || V_TOT > CNT_MAX) begin : g_bad_totals
            $fatal(1, "vga_timing: H_TOT=%0d / V_TOT=%0d exceed 11-bit counters", H_TOT, V_TOT);
        end
    endgenerate

    localparam cnt_t H_LAST  = cnt_t'(H_TOT - 1);
    localparam cnt_t V_LAST  = cnt_t'(V_TOT - 1);
    localparam cnt_t H_VIS_C = cnt_t'(H_VIS);
    localparam cnt_t V_VIS_C = cnt_t'(V_VIS);
    localparam cnt_t H_SY_LO = cnt_t'(H_VIS + H_FP);
    localparam cnt_t H_SY_HI = cnt_t'(H_VIS + H_FP + H_SY);
    localparam cnt_t V_SY_LO = cnt_t'(V_VIS + V_FP);
    localparam cnt_t V_SY_HI = cnt_t'(V_VIS + V_FP + V_SY);

    cnt_t     h_q, h_d, v_q, v_d;
    vid_out_t vid_q, vid_d;
    logic     pix_en, h_wrap, v_wrap, visible, frame_start;

    vga_pix_div #(.CLK_DIV(CLK_DIV)) u_pix_div (
        .clk    (CLK),
        .rst_n  (RST_N),
        .pix_en (pix_en)
    );

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        h_wrap      = (h_q == H_LAST);
        v_wrap      = (v_q == V_LAST);
        visible     = (h_q < H_VIS_C) && (v_q < V_VIS_C);
        frame_start = pix_en && h_wrap && v_wrap;
        h_d         = h_q;
        v_d         = v_q;
        vid_d       = vid_q;
        if (pix_en) begin
            h_d = h_wrap ? '0 : h_q + cnt_t'(1);
            if (h_wrap) v_d = v_wrap ? '0 : v_q + cnt_t'(1);
            // Colour and sync both sample the current position: one pixel of latency.
            vid_d.rgb   = !visible ? RGB_BLANK : (PAINT ? FG_RGB : BG_RGB);
            vid_d.hsync = !in_range(h_q, H_SY_LO, H_SY_HI);
            vid_d.vsync = !in_range(v_q, V_SY_LO, V_SY_HI);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            h_q   <= '0;
            v_q   <= '0;
            vid_q <= VID_RESET;
        end else begin
            h_q   <= h_d;
            v_q   <= v_d;
            vid_q <= vid_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_start ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) frame_cnt_q <= '0;
        else        frame_cnt_q <= frame_cnt_d;
    end

    assign FRAME_CNT = frame_cnt_q;
`else
    assign FRAME_CNT = '0;
`endif

    assign HCOUNT      = h_q;
    assign VCOUNT      = v_q;
    assign PIX_EN      = pix_en;
    assign HSYNC       = vid_q.hsync;
    assign VSYNC       = vid_q.vsync;
    assign RGB         = vid_q.rgb;
    assign FRAME_START = frame_start;

endmodule
